// File: rtl/serial_wide_adder.sv
// Multi-cycle WIDTH-bit adder that walks 2-bit chunks of the operands,
// LSB chunk first, through a single 2-bit gate-level adder slice.

module adder_slice2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] sum,
   output logic       cout
);
   logic c1_s;

   assign sum[0] = a[0] ^ b[0] ^ cin;
   assign c1_s   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
   assign sum[1] = a[1] ^ b[1] ^ c1_s;
   assign cout   = (a[1] & b[1]) | (a[1] & c1_s) | (b[1] & c1_s);
endmodule

module serial_wide_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int N  = WIDTH / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, done_q;

   logic [1:0]       slice_sum_s;
   logic             slice_cout_s;
   logic [WIDTH+1:0] shift_cat_s;
   logic [WIDTH-1:0] part_shift_s;

   adder_slice2 u_slice (
      .a    (a_q[1:0]),
      .b    (b_q[1:0]),
      .cin  (carry_q),
      .sum  (slice_sum_s),
      .cout (slice_cout_s)
   );

   // New chunk enters at the top; concatenation keeps WIDTH=2 legal.
   assign shift_cat_s  = {slice_sum_s, part_q};
   assign part_shift_s = shift_cat_s[WIDTH+1:2];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      part_d  = part_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               part_d  = {WIDTH{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d     = a_q >> 2;
            b_d     = b_q >> 2;
            part_d  = part_shift_s;
            carry_d = slice_cout_s;
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == LAST) begin
               sum_d   = part_shift_s;
               cout_d  = slice_cout_s;
               cnt_d   = {CW{1'b0}};
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // busy/done are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         part_q  <= {WIDTH{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         part_q  <= part_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= (state_d == S_RUN);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_serial_wide_adder.sv
// Directed bench for serial_wide_adder at WIDTH=16 and WIDTH=2.

module tb_serial_wide_adder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = 16'h0000, b = 16'h0000;
   logic        cin = 1'b0;
   logic        busy, done, cout;
   logic [15:0] sum;

   logic        start2 = 1'b0;
   logic [1:0]  a2 = 2'b00, b2 = 2'b00;
   logic        cin2 = 1'b0;
   logic        busy2, done2, cout2;
   logic [1:0]  sum2;

   int tests = 0;
   int fails = 0;

   serial_wide_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_wide_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full operation on the WIDTH=16 instance, checking latency and result.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] es, input logic ec);
      int cycles;
      int busy_cnt;
      int overlap;
      a = av; b = bv; cin = cv; start = 1'b1;
      tick();
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      chk({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
      cycles = 0; busy_cnt = busy ? 1 : 0; overlap = 0;
      while (done !== 1'b1 && cycles < 40) begin
         tick();
         cycles++;
         if (busy === 1'b1) busy_cnt++;
         if (busy === 1'b1 && done === 1'b1) overlap++;
      end
      chk({tag, "_latency"}, 32'(cycles), 32'd8);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
      chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
      tick();
      chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [15:0] av [20];
      logic [15:0] bv [20];
      logic        cv [20];
      logic [16:0] e0, e1;
      logic [2:0]  e2;
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] re;
      int          seen;

      // Reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_sum2", {29'd0, cout2, sum2}, 32'd0);

      run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      run_op("ffff_0_c1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
      run_op("ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

      // start held high while operands change every cycle
      for (int k = 0; k < 20; k++) begin
         av[k] = 16'(16'h0123 + 16'(k) * 16'h1111);
         bv[k] = 16'hF00D ^ 16'(16'(k) * 16'h0707);
         cv[k] = k[0];
      end
      e0 = {1'b0, av[0]} + {1'b0, bv[0]} + {16'd0, cv[0]};
      e1 = {1'b0, av[10]} + {1'b0, bv[10]} + {16'd0, cv[10]};
      for (int k = 0; k < 20; k++) begin
         a = av[k]; b = bv[k]; cin = cv[k]; start = 1'b1;
         tick();
         if (k >= 1 && k <= 7) begin
            chk("b2b_done_idle_run1", {31'd0, done}, 32'd0);
            chk("b2b_sum_hold_prev", {15'd0, cout, sum}, {15'd0, 1'b1, 16'hFFFF});
         end else if (k == 8) begin
            chk("b2b_done1", {31'd0, done}, 32'd1);
            chk("b2b_res1", {15'd0, cout, sum}, {15'd0, e0});
         end else if (k >= 9 && k <= 17) begin
            chk("b2b_done_idle_run2", {31'd0, done}, 32'd0);
            chk("b2b_sum_hold_res1", {15'd0, cout, sum}, {15'd0, e0});
         end else if (k == 18) begin
            chk("b2b_done2", {31'd0, done}, 32'd1);
            chk("b2b_res2", {15'd0, cout, sum}, {15'd0, e1});
         end else begin
            chk("b2b_done_after2", {31'd0, done}, 32'd0);
         end
      end
      start = 1'b0;
      tick();

      // Abort with reset during RUN cycle 4
      a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_sum", {16'd0, sum}, 32'd0);
      chk("abort_cout", {31'd0, cout}, 32'd0);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

      // rst and start on the same edge
      a = 16'h1111; b = 16'h2222; rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", {31'd0, busy}, 32'd0);
      chk("rst_start_sum", {16'd0, sum}, 32'd0);
      tick();
      chk("rst_start_busy2", {30'd0, busy, done}, 32'd0);

      // WIDTH=2 exhaustive
      for (int v = 0; v < 32; v++) begin
         a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0];
         e2 = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
         start2 = 1'b1;
         tick();
         start2 = 1'b0;
         a2 = ~a2; b2 = ~b2; cin2 = ~cin2;
         chk("w2_busy", {30'd0, busy2, done2}, 32'd2);
         tick();
         chk("w2_done", {30'd0, busy2, done2}, 32'd1);
         chk("w2_result", {29'd0, cout2, sum2}, {29'd0, e2});
         tick();
      end

      // WIDTH=16 random vectors
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         re = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         run_op("rand", ra, rb, rc, re[15:0], re[16]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
